// File: rtl/int2fp.sv
// Multi-cycle signed 32-bit integer to IEEE-754 single converter using start/done handshake.
// Latency 4..35 cycles (2 for zero); define INT2FP_ROUND_NEAREST_EN for round-to-nearest-even, else truncate.
module int2fp (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    output logic [31:0] fp,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        PACK  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] a_reg;
    logic [31:0] mag;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        sign;
    logic        zero;

    logic [22:0] frac_trunc;
    logic [23:0] frac_inc;
    logic        round_up;

    assign frac_trunc = mag[30:8];
    assign frac_inc   = {1'b0, frac_trunc} + 24'd1;

`ifdef INT2FP_ROUND_NEAREST_EN
    // Guard set and either sticky or odd lsb: ties go to even.
    assign round_up = mag[7] & ((|mag[6:0]) | mag[8]);
`else
    assign round_up = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ABS;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                ABS:     state_nxt = (a_reg == 32'd0) ? PACK : NORM;
                NORM:    state_nxt = mag[31] ? ROUND : NORM;
                ROUND:   state_nxt = PACK;
                PACK:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg <= 32'd0;
            mag   <= 32'd0;
            exp   <= 8'd0;
            frac  <= 23'd0;
            sign  <= 1'b0;
            zero  <= 1'b0;
            fp    <= 32'd0;
            done  <= 1'b0;
        end else if (start) begin
            a_reg <= a;
            zero  <= 1'b0;
            fp    <= 32'd0;
            done  <= 1'b0;
        end else begin
            case (state)
                ABS: begin
                    if (a_reg == 32'd0) begin
                        zero <= 1'b1;
                    end else begin
                        sign <= a_reg[31];
                        // 0x80000000 negates to itself, which is the correct unsigned magnitude.
                        mag  <= a_reg[31] ? (~a_reg + 32'd1) : a_reg;
                        exp  <= 8'd158;
                    end
                end
                NORM: begin
                    if (!mag[31]) begin
                        mag <= mag << 1;
                        exp <= exp - 8'd1;
                    end
                end
                ROUND: begin
                    if (round_up) begin
                        frac <= frac_inc[22:0];
                        if (frac_inc[23]) begin
                            exp <= exp + 8'd1;
                        end
                    end else begin
                        frac <= frac_trunc;
                    end
                end
                PACK: begin
                    fp   <= zero ? 32'd0 : {sign, exp, frac};
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
